// File: rtl/riscv_crypto_fu_sha2_pipe_if.sv
// riscv_crypto_fu_sha2_pipe_if: request/response bundle for the SHA-2 sigma/sum unit.
interface riscv_crypto_fu_sha2_pipe_if #(parameter int XLEN = 32);
    logic            flush, in_valid, in_ready, out_valid, out_ready, out_err, busy;
    logic [XLEN-1:0] rs1, rs2, out_rd;
    logic            op_ssha256_sig0, op_ssha256_sig1, op_ssha256_sum0, op_ssha256_sum1;
    logic            op_ssha512_sum0r, op_ssha512_sum1r, op_ssha512_sig0l, op_ssha512_sig0h;
    logic            op_ssha512_sig1l, op_ssha512_sig1h;
    logic            op_ssha512_sig0, op_ssha512_sig1, op_ssha512_sum0, op_ssha512_sum1;

    modport master (
        output flush, in_valid, rs1, rs2, out_ready,
               op_ssha256_sig0, op_ssha256_sig1, op_ssha256_sum0, op_ssha256_sum1,
               op_ssha512_sum0r, op_ssha512_sum1r, op_ssha512_sig0l, op_ssha512_sig0h,
               op_ssha512_sig1l, op_ssha512_sig1h,
               op_ssha512_sig0, op_ssha512_sig1, op_ssha512_sum0, op_ssha512_sum1,
        input  in_ready, out_valid, out_rd, out_err, busy
    );

    modport slave (
        input  flush, in_valid, rs1, rs2, out_ready,
               op_ssha256_sig0, op_ssha256_sig1, op_ssha256_sum0, op_ssha256_sum1,
               op_ssha512_sum0r, op_ssha512_sum1r, op_ssha512_sig0l, op_ssha512_sig0h,
               op_ssha512_sig1l, op_ssha512_sig1h,
               op_ssha512_sig0, op_ssha512_sig1, op_ssha512_sum0, op_ssha512_sum1,
        output in_ready, out_valid, out_rd, out_err, busy
    );
endinterface

// File: rtl/riscv_crypto_fu_sha2_pipe.sv
// riscv_crypto_fu_sha2_pipe: SHA-256/512 sigma/sum unit with a 1- or 2-stage
// valid/ready pipeline, flush and illegal-op reporting.
module riscv_crypto_fu_sha2_pipe #(
    parameter int XLEN      = 32,
    parameter int SHA256_EN = 1,
    parameter int SHA512_EN = 1,
    parameter int STAGES    = 1
) (
    input logic                       g_clk,
    input logic                       g_resetn,
    riscv_crypto_fu_sha2_pipe_if.slave f
);
    localparam logic E256 = SHA256_EN != 0;
    localparam logic E32  = SHA512_EN != 0 && XLEN == 32;
    localparam logic E64  = SHA512_EN != 0 && XLEN == 64;
    localparam logic [13:0] OP_EN = {{4{E64}}, {6{E32}}, {4{E256}}};

    function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    logic [13:0]     op_in, s_op;
    logic            legal_in, s_legal, pv, rdy, up_busy, o_v, o_err, o_load;
    logic [XLEN-1:0] s_rs1, s_rs2, o_rd, res;
    logic [63:0]     x, y, r64, res64;
    logic [31:0]     x32, y32, r32;
    logic [31:0]     t [10];
    logic            unused_bits;

    assign op_in = {f.op_ssha512_sum1, f.op_ssha512_sum0, f.op_ssha512_sig1, f.op_ssha512_sig0,
                    f.op_ssha512_sig1h, f.op_ssha512_sig1l, f.op_ssha512_sig0h, f.op_ssha512_sig0l,
                    f.op_ssha512_sum1r, f.op_ssha512_sum0r,
                    f.op_ssha256_sum1, f.op_ssha256_sum0, f.op_ssha256_sig1, f.op_ssha256_sig0};
    assign legal_in = op_in != '0 && (op_in & (op_in - 14'd1)) == '0 && (op_in & ~OP_EN) == '0;

    generate
        if (STAGES == 2) begin : g_two
            logic            a_v, a_legal;
            logic [XLEN-1:0] a_rs1, a_rs2;
            logic [13:0]     a_op;
            always_ff @(posedge g_clk or negedge g_resetn) begin
                if (!g_resetn) begin
                    a_v     <= 1'b0;
                    a_legal <= 1'b0;
                    a_rs1   <= '0;
                    a_rs2   <= '0;
                    a_op    <= '0;
                end else if (f.flush) begin
                    a_v <= 1'b0;
                end else if (rdy) begin
                    a_v <= f.in_valid;
                    if (f.in_valid) begin
                        a_legal <= legal_in;
                        a_rs1   <= f.rs1;
                        a_rs2   <= f.rs2;
                        a_op    <= op_in;
                    end
                end
            end
            assign s_rs1   = a_rs1;
            assign s_rs2   = a_rs2;
            assign s_op    = a_op;
            assign s_legal = a_legal;
            assign pv      = a_v;
            assign up_busy = a_v;
            assign rdy     = !a_v || o_load;
        end else begin : g_one
            assign s_rs1   = f.rs1;
            assign s_rs2   = f.rs2;
            assign s_op    = op_in;
            assign s_legal = legal_in;
            assign pv      = f.in_valid;
            assign up_busy = 1'b0;
            assign rdy     = o_load;
        end
    endgenerate

    assign x   = 64'(s_rs1);
    assign y   = 64'(s_rs2);
    assign x32 = x[31:0];
    assign y32 = y[31:0];

    // Ops are one-hot when legal, so each result is masked by its op bit and OR-merged.
    always_comb begin
        t[0] = ror32(x32, 7) ^ ror32(x32, 18) ^ (x32 >> 3);
        t[1] = ror32(x32, 17) ^ ror32(x32, 19) ^ (x32 >> 10);
        t[2] = ror32(x32, 2) ^ ror32(x32, 13) ^ ror32(x32, 22);
        t[3] = ror32(x32, 6) ^ ror32(x32, 11) ^ ror32(x32, 25);
        t[4] = (x32 << 25) ^ (x32 << 30) ^ (x32 >> 28) ^ (y32 >> 7) ^ (y32 >> 2) ^ (y32 << 4);
        t[5] = (x32 << 23) ^ (x32 >> 14) ^ (x32 >> 18) ^ (y32 >> 9) ^ (y32 << 18) ^ (y32 << 14);
        t[6] = (x32 >> 1) ^ (x32 >> 7) ^ (x32 >> 8) ^ (y32 << 31) ^ (y32 << 25) ^ (y32 << 24);
        t[7] = (x32 >> 1) ^ (x32 >> 7) ^ (x32 >> 8) ^ (y32 << 31) ^ (y32 << 24);
        t[8] = (x32 << 3) ^ (x32 >> 6) ^ (x32 >> 19) ^ (y32 >> 29) ^ (y32 << 26) ^ (y32 << 13);
        t[9] = (x32 << 3) ^ (x32 >> 6) ^ (x32 >> 19) ^ (y32 >> 29) ^ (y32 << 13);
        r32 = '0;
        for (int i = 0; i < 10; i++) r32 = r32 | (t[i] & {32{s_op[i]}});
        r64 = ({64{s_op[10]}} & (ror64(x, 1) ^ ror64(x, 8) ^ (x >> 7)))
            | ({64{s_op[11]}} & (ror64(x, 19) ^ ror64(x, 61) ^ (x >> 6)))
            | ({64{s_op[12]}} & (ror64(x, 28) ^ ror64(x, 34) ^ ror64(x, 39)))
            | ({64{s_op[13]}} & (ror64(x, 14) ^ ror64(x, 18) ^ ror64(x, 41)));
        res64 = {{32{r32[31]}}, r32} | r64;
    end

    assign res         = s_legal ? res64[XLEN-1:0] : '0;
    assign unused_bits = ^{y[63:32], res64};
    assign o_load      = !o_v || f.out_ready;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            o_v   <= 1'b0;
            o_rd  <= '0;
            o_err <= 1'b0;
        end else if (f.flush) begin
            o_v <= 1'b0;
        end else if (o_load) begin
            o_v <= pv;
            if (pv) begin
                o_rd  <= res;
                o_err <= !s_legal;
            end
        end
    end

    assign f.in_ready  = !f.flush && rdy;
    assign f.out_valid = o_v;
    assign f.out_rd    = o_rd;
    assign f.out_err   = o_err;
    assign f.busy      = o_v || up_busy;
endmodule

// File: tb/tb_riscv_crypto_fu_sha2_pipe.sv
// tb_riscv_crypto_fu_sha2_pipe: directed checks of an XLEN=32/1-stage and an
// XLEN=64/2-stage instance against hand-computed results.
module tb_riscv_crypto_fu_sha2_pipe;
    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    always #5 g_clk = ~g_clk;

    riscv_crypto_fu_sha2_pipe_if #(.XLEN(32)) f32 ();
    riscv_crypto_fu_sha2_pipe_if #(.XLEN(64)) f64 ();
    logic [13:0] op32, op64;

    // op bit order: 0-3 sha256 sig0/sig1/sum0/sum1, 4-9 sum0r/sum1r/sig0l/sig0h/sig1l/sig1h, 10-13 sha512 sig0/sig1/sum0/sum1
    assign {f32.op_ssha512_sum1, f32.op_ssha512_sum0, f32.op_ssha512_sig1, f32.op_ssha512_sig0,
            f32.op_ssha512_sig1h, f32.op_ssha512_sig1l, f32.op_ssha512_sig0h, f32.op_ssha512_sig0l,
            f32.op_ssha512_sum1r, f32.op_ssha512_sum0r,
            f32.op_ssha256_sum1, f32.op_ssha256_sum0, f32.op_ssha256_sig1, f32.op_ssha256_sig0} = op32;
    assign {f64.op_ssha512_sum1, f64.op_ssha512_sum0, f64.op_ssha512_sig1, f64.op_ssha512_sig0,
            f64.op_ssha512_sig1h, f64.op_ssha512_sig1l, f64.op_ssha512_sig0h, f64.op_ssha512_sig0l,
            f64.op_ssha512_sum1r, f64.op_ssha512_sum0r,
            f64.op_ssha256_sum1, f64.op_ssha256_sum0, f64.op_ssha256_sig1, f64.op_ssha256_sig0} = op64;

    riscv_crypto_fu_sha2_pipe #(.XLEN(32), .STAGES(1)) u32 (.g_clk(g_clk), .g_resetn(g_resetn), .f(f32));
    riscv_crypto_fu_sha2_pipe #(.XLEN(64), .STAGES(2)) u64 (.g_clk(g_clk), .g_resetn(g_resetn), .f(f64));

    int total = 0;
    int bad = 0;
    int tx = 0;
    int rx = 0;
    logic [63:0] sexp [8] = '{64'h00000000_02004000, 64'h00000000_04008000, 64'h00000000_08010000,
                              64'h00000000_10020001, 64'h00000000_20040002, 64'h00000000_40080004,
                              64'hFFFFFFFF_80100008, 64'h00000000_00200011};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic req32(input string tag, input logic [13:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] rd, input logic err);
        @(negedge g_clk);
        op32 = op; f32.rs1 = a; f32.rs2 = b; f32.in_valid = 1'b1;
        @(negedge g_clk);
        f32.in_valid = 1'b0; op32 = '0;
        chk({tag, ".valid"}, 64'(f32.out_valid), 64'd1);
        chk({tag, ".rd"}, 64'(f32.out_rd), 64'(rd));
        chk({tag, ".err"}, 64'(f32.out_err), 64'(err));
    endtask

    task automatic req64(input string tag, input logic [13:0] op, input logic [63:0] a,
                         input logic [63:0] rd, input logic err);
        @(negedge g_clk);
        op64 = op; f64.rs1 = a; f64.rs2 = '0; f64.in_valid = 1'b1;
        @(negedge g_clk);
        f64.in_valid = 1'b0; op64 = '0;
        chk({tag, ".early"}, 64'(f64.out_valid), 64'd0);
        @(negedge g_clk);
        chk({tag, ".valid"}, 64'(f64.out_valid), 64'd1);
        chk({tag, ".rd"}, f64.out_rd, rd);
        chk({tag, ".err"}, 64'(f64.out_err), 64'(err));
    endtask

    initial begin
        op32 = '0; op64 = '0;
        f32.flush = 1'b0; f32.in_valid = 1'b0; f32.rs1 = '0; f32.rs2 = '0; f32.out_ready = 1'b1;
        f64.flush = 1'b0; f64.in_valid = 1'b0; f64.rs1 = '0; f64.rs2 = '0; f64.out_ready = 1'b1;
        #1;
        chk("rst32.valid", 64'(f32.out_valid), 64'd0);
        chk("rst32.busy", 64'(f32.busy), 64'd0);
        chk("rst32.rd", 64'(f32.out_rd), 64'd0);
        chk("rst64.valid", 64'(f64.out_valid), 64'd0);
        chk("rst64.err", 64'(f64.out_err), 64'd0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        #1;
        chk("rst32.in_ready", 64'(f32.in_ready), 64'd1);
        chk("rst64.in_ready", 64'(f64.in_ready), 64'd1);

        req32("s256sig0", 14'h0001, 32'h1, 32'h0, 32'h02004000, 1'b0);
        req32("s256sig1", 14'h0002, 32'h1, 32'h0, 32'h0000A000, 1'b0);
        req32("s256sum0", 14'h0004, 32'h1, 32'h0, 32'h40080400, 1'b0);
        req32("s256sum1", 14'h0008, 32'h1, 32'h0, 32'h04200080, 1'b0);
        req32("sum0r", 14'h0010, 32'h1, 32'h0, 32'h42000000, 1'b0);
        req32("sum1r", 14'h0020, 32'h0, 32'h1, 32'h00044000, 1'b0);
        req32("sig0l", 14'h0040, 32'h0, 32'h1, 32'h83000000, 1'b0);
        req32("sig0h", 14'h0080, 32'h0, 32'h1, 32'h81000000, 1'b0);
        req32("sig1l", 14'h0100, 32'h0, 32'h1, 32'h04002000, 1'b0);
        req32("sig1h", 14'h0200, 32'h0, 32'h1, 32'h00002000, 1'b0);
        req32("ill_zero", 14'h0000, 32'h1, 32'h1, 32'h0, 1'b1);
        req32("ill_two", 14'h0003, 32'h1, 32'h1, 32'h0, 1'b1);
        req32("ill_rv64op", 14'h0400, 32'h1, 32'h0, 32'h0, 1'b1);

        req64("s256sum0_64", 14'h0004, 64'hFFFFFFFF_00000002, 64'hFFFFFFFF_80100800, 1'b0);
        req64("s512sig0", 14'h0400, 64'h1, 64'h81000000_00000000, 1'b0);
        req64("s512sig1", 14'h0800, 64'h1, 64'h00002000_00000008, 1'b0);
        req64("s512sum0", 14'h1000, 64'h1, 64'h00000010_42000000, 1'b0);
        req64("s512sum1", 14'h2000, 64'h1, 64'h00044000_00800000, 1'b0);
        req64("ill_sum0r64", 14'h0010, 64'h1, 64'h0, 1'b1);

        // streaming: 8 back-to-back sha256 sig0 requests with a 3-cycle output stall
        for (int i = 0; i < 40 && rx < 8; i++) begin
            @(negedge g_clk);
            f64.in_valid = tx < 8;
            op64 = 14'h0001;
            f64.rs1 = 64'h1 << tx;
            f64.out_ready = !(i >= 4 && i <= 6);
            #1;
            if (i == 5) chk("stall.in_ready", 64'(f64.in_ready), 64'd0);
            if (f64.out_valid) begin
                chk($sformatf("stream%0d", rx), f64.out_rd, sexp[rx]);
                if (f64.out_ready) rx++;
            end
            if (f64.in_valid && f64.in_ready) tx++;
        end
        f64.in_valid = 1'b0; op64 = '0; f64.out_ready = 1'b1;
        chk("stream.rx", 64'(rx), 64'd8);
        chk("stream.tx", 64'(tx), 64'd8);
        @(negedge g_clk);
        chk("stream.nodup", 64'(f64.out_valid), 64'd0);
        chk("stream.idle", 64'(f64.busy), 64'd0);

        // flush with both stages full
        @(negedge g_clk);
        f64.out_ready = 1'b0; op64 = 14'h0001; f64.rs1 = 64'h1; f64.in_valid = 1'b1;
        @(negedge g_clk);
        f64.rs1 = 64'h2;
        @(negedge g_clk);
        f64.in_valid = 1'b0;
        #1;
        chk("full.busy", 64'(f64.busy), 64'd1);
        chk("full.valid", 64'(f64.out_valid), 64'd1);
        chk("full.rd", f64.out_rd, 64'h02004000);
        f64.flush = 1'b1; f64.in_valid = 1'b1; f64.out_ready = 1'b1;
        #1;
        chk("flush.in_ready", 64'(f64.in_ready), 64'd0);
        @(negedge g_clk);
        f64.flush = 1'b0; f64.in_valid = 1'b0; op64 = '0;
        chk("flush.busy", 64'(f64.busy), 64'd0);
        chk("flush.valid", 64'(f64.out_valid), 64'd0);
        req64("postflush", 14'h0400, 64'h1, 64'h81000000_00000000, 1'b0);

        // reset mid-operation
        @(negedge g_clk);
        op64 = 14'h0001; f64.rs1 = 64'h1; f64.in_valid = 1'b1;
        @(negedge g_clk);
        f64.in_valid = 1'b0; op64 = '0;
        chk("inflight.busy", 64'(f64.busy), 64'd1);
        g_resetn = 1'b0;
        #1;
        chk("rstmid.busy", 64'(f64.busy), 64'd0);
        chk("rstmid.valid", 64'(f64.out_valid), 64'd0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(negedge g_clk);
        chk("rstmid.nopartial", 64'(f64.out_valid), 64'd0);
        req64("postreset", 14'h0004, 64'hFFFFFFFF_00000002, 64'hFFFFFFFF_80100800, 1'b0);
        req32("postreset32", 14'h0040, 32'h0, 32'h1, 32'h83000000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
